add4_resp_checker: RTL and testbench
====================================

# add4_resp_checker

Self-checking response checker for the four-operand 4-bit adder (`add4`: sum = a+b+c+d mod 16, ov = carry-out). It is the receiving end of the adder's exhaustive stimulus sweep: it samples each applied vector together with the DUT's `sum`/`ov`, compares them against a golden model, and checks that the vectors arrive in sweep order. It accumulates error statistics and reports pass/fail when the sweep ends. It sits beside the DUT on the FPGA test harness, so no simulator `$monitor` is needed.

## Interface
- `VEC_COUNT`, 65536, number of vectors in one sweep (1..65536).
- `CNT_W`, 17, width of vector counters; must hold `VEC_COUNT`.
- `ERR_W`, 16, width of error counters (saturating).
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse; begins a sweep from IDLE or DONE.
- `vec_valid`  in  1  a/b/c/d/dut_sum/dut_ov valid this cycle.
- `a`, `b`, `c`, `d`  in  4 each  applied operands.
- `dut_sum`  in  4  DUT sum output.
- `dut_ov`  in  1  DUT overflow output.
- `busy`  out  1  state is RUN.
- `done`  out  1  state is DONE.
- `pass`  out  1  done and both error counters are zero.
- `vec_cnt`  out  CNT_W  vectors accepted this sweep.
- `err_cnt`  out  ERR_W  result mismatches.
- `seq_err_cnt`  out  ERR_W  out-of-order vectors.
- `first_fail_valid`  out  1  a result mismatch has been captured.
- `first_fail_vec`  out  16  {d,c,b,a} of the first mismatch.
- `first_fail_sum`  out  5  {dut_ov,dut_sum} of the first mismatch.

## Operation
- FSM states: IDLE, RUN, DONE. IDLE→RUN on `start`. RUN→DONE on the accepted vector that makes `vec_cnt == VEC_COUNT`. DONE→RUN on `start`. No other transitions.
- Entering RUN clears all counters, `first_fail_*`, and the expected index (set to 0).
- `start` during RUN is ignored. `vec_valid` in IDLE or DONE is ignored; no counter changes.
- Accepted vector (RUN && `vec_valid`):
  - `vec_cnt` increments.
  - Golden model: full = a+b+c+d, 6 bits, max 60. exp_sum = full[3:0]; exp_ov = (full > 15).
  - Mismatch if `dut_sum != exp_sum` or `dut_ov != exp_ov`. A mismatch increments `err_cnt`.
  - On the first mismatch, capture `first_fail_vec`/`first_fail_sum` and set `first_fail_valid`. Later mismatches do not overwrite the capture.
  - Order check: idx = {d,c,b,a}. If idx != expected index, increment `seq_err_cnt`. The expected index then becomes idx+1 mod 2^16 in all cases (resync), so one skipped vector produces exactly one error.
- Error counters saturate at 2^ERR_W−1 and never wrap.
- `pass` = DONE && `err_cnt == 0` && `seq_err_cnt == 0`; it is 0 outside DONE.
- Counters and capture registers hold their values in DONE until the next `start`.

## Timing
- All outputs are registered. Reset value of every output is 0, and the state resets to IDLE.
- `start` sampled at edge k: `busy` = 1 after edge k, counters zero.
- Vector sampled at edge k: its effect on all counters and `first_fail_*` is visible after edge k (1-cycle latency).
- Last vector sampled at edge k: `done` = 1 and `busy` = 0 after edge k, and `pass` is valid in the same cycle.
- A `start` and a `vec_valid` in the same cycle from IDLE/DONE: the start is taken, and the vector is ignored.
- A `rst` assertion at any point, including mid-RUN, returns the block to IDLE with all outputs 0 immediately (asynchronous).
- Back-to-back `vec_valid` on every cycle is fully supported; gaps of any length are allowed.

## Structure
- Package `add4_chk_pkg`:
  - state enum {IDLE, RUN, DONE};
  - `VEC_W = 16`;
  - function `add4_expected(a,b,c,d)` returning {ov,sum}.
- Sub-module `add4_ref_model`: the combinational golden adder wrapping the package function, so the same model can be reused against `add4` in other benches.
- The top level holds the FSM, the counters, and the capture registers.

## Test plan
- Reset mid-RUN after 100 vectors → all outputs 0, state IDLE; the next `start` → `busy` = 1 with zeroed counters.
- Full sweep, `VEC_COUNT` = 65536, ordered vectors with correct results every cycle → `done` one cycle after the last vector, `vec_cnt` = 65536, `err_cnt` = 0, `seq_err_cnt` = 0, `pass` = 1.
- Fault injection on vector a=15, b=1, c=0, d=0 (expected sum=0, ov=1), driving `dut_ov` = 0 → `err_cnt` = 1, `first_fail_vec` = 0x001F, `first_fail_sum` = 0x00, `pass` = 0. A later fault leaves the capture unchanged.
- `VEC_COUNT` = 16, indices 0–4 then 6–16, all results correct → `seq_err_cnt` = 1, `err_cnt` = 0, `done` after the 16th vector, `pass` = 0.
- `vec_valid` pulses in IDLE and DONE, plus a `start` in RUN → no counter change and no restart. Random `vec_valid` gaps in RUN → `vec_cnt` counts only valid cycles.
- `ERR_W` = 4, `VEC_COUNT` = 20, all results wrong → `err_cnt` saturates at 15, `first_fail_vec` = 0x0000.

Source files
------------

// File: rtl/add4_chk_pkg.sv
// Shared types and the golden four-operand adder used by the add4 response checker.
package add4_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_e;

  localparam int unsigned VEC_W = 16;

  // Returns {ov, sum}; ov is any carry out of the 4-bit sum, not just bit 4.
  function automatic logic [4:0] add4_expected(input logic [3:0] a,
                                               input logic [3:0] b,
                                               input logic [3:0] c,
                                               input logic [3:0] d);
    logic [5:0] full;
    full = 6'(a) + 6'(b) + 6'(c) + 6'(d);
    return {(full > 6'd15), full[3:0]};
  endfunction

endpackage

// File: rtl/add4_ref_model.sv
// Combinational golden model of the add4 adder, reusable in other benches.
module add4_ref_model
  import add4_chk_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] c,
  input  logic [3:0] d,
  output logic [3:0] sum,
  output logic       ov
);

  assign {ov, sum} = add4_expected(a, b, c, d);

endmodule

// File: rtl/add4_resp_checker.sv
// Response checker for the add4 exhaustive sweep: compares results against the
// golden model, checks vector order, and reports pass/fail at sweep end.
module add4_resp_checker
  import add4_chk_pkg::*;
#(
  parameter int unsigned VEC_COUNT = 65536,
  parameter int unsigned CNT_W     = 17,
  parameter int unsigned ERR_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               vec_valid,
  input  logic [3:0]         a,
  input  logic [3:0]         b,
  input  logic [3:0]         c,
  input  logic [3:0]         d,
  input  logic [3:0]         dut_sum,
  input  logic               dut_ov,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [CNT_W-1:0]   vec_cnt,
  output logic [ERR_W-1:0]   err_cnt,
  output logic [ERR_W-1:0]   seq_err_cnt,
  output logic               first_fail_valid,
  output logic [VEC_W-1:0]   first_fail_vec,
  output logic [4:0]         first_fail_sum
);

  chk_state_e       state_q, state_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [ERR_W-1:0] seq_err_cnt_q, seq_err_cnt_d;
  logic             ff_valid_q, ff_valid_d;
  logic [VEC_W-1:0] ff_vec_q, ff_vec_d;
  logic [4:0]       ff_sum_q, ff_sum_d;
  logic [VEC_W-1:0] exp_idx_q, exp_idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic [3:0]       exp_sum;
  logic             exp_ov;
  logic [VEC_W-1:0] idx;
  logic             mismatch;
  logic             last_vec;

  add4_ref_model u_ref (
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .sum (exp_sum),
    .ov  (exp_ov)
  );

  assign idx      = {d, c, b, a};
  assign mismatch = (dut_sum != exp_sum) || (dut_ov != exp_ov);
  assign last_vec = (vec_cnt_q == CNT_W'(VEC_COUNT - 1));

  always_comb begin
    state_d       = state_q;
    vec_cnt_d     = vec_cnt_q;
    err_cnt_d     = err_cnt_q;
    seq_err_cnt_d = seq_err_cnt_q;
    ff_valid_d    = ff_valid_q;
    ff_vec_d      = ff_vec_q;
    ff_sum_d      = ff_sum_q;
    exp_idx_d     = exp_idx_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d       = RUN;
          vec_cnt_d     = '0;
          err_cnt_d     = '0;
          seq_err_cnt_d = '0;
          ff_valid_d    = 1'b0;
          ff_vec_d      = '0;
          ff_sum_d      = '0;
          exp_idx_d     = '0;
        end
      end
      RUN: begin
        if (vec_valid) begin
          vec_cnt_d = vec_cnt_q + CNT_W'(1);
          if (mismatch) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
            if (!ff_valid_q) begin
              ff_valid_d = 1'b1;
              ff_vec_d   = idx;
              ff_sum_d   = {dut_ov, dut_sum};
            end
          end
          // Resync to the observed index so a single skip costs one error.
          if (idx != exp_idx_q && seq_err_cnt_q != '1) seq_err_cnt_d = seq_err_cnt_q + ERR_W'(1);
          exp_idx_d = idx + VEC_W'(1);
          if (last_vec) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
    pass_d = (state_d == DONE) && (err_cnt_d == '0) && (seq_err_cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      vec_cnt_q     <= '0;
      err_cnt_q     <= '0;
      seq_err_cnt_q <= '0;
      ff_valid_q    <= 1'b0;
      ff_vec_q      <= '0;
      ff_sum_q      <= '0;
      exp_idx_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      vec_cnt_q     <= vec_cnt_d;
      err_cnt_q     <= err_cnt_d;
      seq_err_cnt_q <= seq_err_cnt_d;
      ff_valid_q    <= ff_valid_d;
      ff_vec_q      <= ff_vec_d;
      ff_sum_q      <= ff_sum_d;
      exp_idx_q     <= exp_idx_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign vec_cnt          = vec_cnt_q;
  assign err_cnt          = err_cnt_q;
  assign seq_err_cnt      = seq_err_cnt_q;
  assign first_fail_valid = ff_valid_q;
  assign first_fail_vec   = ff_vec_q;
  assign first_fail_sum   = ff_sum_q;

endmodule

// File: tb/tb_add4_resp_checker.sv
// Scoreboard bench for add4_resp_checker: four instances with different sweep
// lengths share the vector bus; each is started independently.
module tb_add4_resp_checker;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        pass;
    logic [16:0] vc;
    logic [15:0] err;
    logic [15:0] seq;
    logic        ffv;
    logic [15:0] ffvec;
    logic [4:0]  ffsum;
  } obs_t;

  typedef struct {
    int    which;
    string name;
    obs_t  exp;
  } sb_t;

  localparam int FULL = 0, SMALL = 1, FLT = 2, SAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_s [4];
  logic vec_valid = 1'b0;
  logic [3:0] a = '0, b = '0, c = '0, d = '0, dut_sum = '0;
  logic dut_ov = 1'b0;

  logic        busy_o [4];
  logic        done_o [4];
  logic        pass_o [4];
  logic [16:0] vc_o   [4];
  logic [15:0] err_o  [3];
  logic [15:0] seq_o  [3];
  logic [3:0]  err_sat, seq_sat;
  logic        ffv_o  [4];
  logic [15:0] ffvec_o[4];
  logic [4:0]  ffsum_o[4];
  obs_t        act    [4];

  sb_t sb_q[$];
  int  checks = 0;
  int  failures = 0;

  always #5 clk = ~clk;

  add4_resp_checker #(.VEC_COUNT(65536), .CNT_W(17), .ERR_W(16)) u_full (
    .clk(clk), .rst(rst), .start(start_s[FULL]), .vec_valid(vec_valid),
    .a(a), .b(b), .c(c), .d(d), .dut_sum(dut_sum), .dut_ov(dut_ov),
    .busy(busy_o[FULL]), .done(done_o[FULL]), .pass(pass_o[FULL]), .vec_cnt(vc_o[FULL]),
    .err_cnt(err_o[FULL]), .seq_err_cnt(seq_o[FULL]), .first_fail_valid(ffv_o[FULL]),
    .first_fail_vec(ffvec_o[FULL]), .first_fail_sum(ffsum_o[FULL]));

  add4_resp_checker #(.VEC_COUNT(16), .CNT_W(17), .ERR_W(16)) u_small (
    .clk(clk), .rst(rst), .start(start_s[SMALL]), .vec_valid(vec_valid),
    .a(a), .b(b), .c(c), .d(d), .dut_sum(dut_sum), .dut_ov(dut_ov),
    .busy(busy_o[SMALL]), .done(done_o[SMALL]), .pass(pass_o[SMALL]), .vec_cnt(vc_o[SMALL]),
    .err_cnt(err_o[SMALL]), .seq_err_cnt(seq_o[SMALL]), .first_fail_valid(ffv_o[SMALL]),
    .first_fail_vec(ffvec_o[SMALL]), .first_fail_sum(ffsum_o[SMALL]));

  add4_resp_checker #(.VEC_COUNT(64), .CNT_W(17), .ERR_W(16)) u_flt (
    .clk(clk), .rst(rst), .start(start_s[FLT]), .vec_valid(vec_valid),
    .a(a), .b(b), .c(c), .d(d), .dut_sum(dut_sum), .dut_ov(dut_ov),
    .busy(busy_o[FLT]), .done(done_o[FLT]), .pass(pass_o[FLT]), .vec_cnt(vc_o[FLT]),
    .err_cnt(err_o[FLT]), .seq_err_cnt(seq_o[FLT]), .first_fail_valid(ffv_o[FLT]),
    .first_fail_vec(ffvec_o[FLT]), .first_fail_sum(ffsum_o[FLT]));

  add4_resp_checker #(.VEC_COUNT(20), .CNT_W(17), .ERR_W(4)) u_sat (
    .clk(clk), .rst(rst), .start(start_s[SAT]), .vec_valid(vec_valid),
    .a(a), .b(b), .c(c), .d(d), .dut_sum(dut_sum), .dut_ov(dut_ov),
    .busy(busy_o[SAT]), .done(done_o[SAT]), .pass(pass_o[SAT]), .vec_cnt(vc_o[SAT]),
    .err_cnt(err_sat), .seq_err_cnt(seq_sat), .first_fail_valid(ffv_o[SAT]),
    .first_fail_vec(ffvec_o[SAT]), .first_fail_sum(ffsum_o[SAT]));

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      act[i].busy  = busy_o[i];
      act[i].done  = done_o[i];
      act[i].pass  = pass_o[i];
      act[i].vc    = vc_o[i];
      act[i].err   = (i == SAT) ? {12'b0, err_sat} : err_o[i % 3];
      act[i].seq   = (i == SAT) ? {12'b0, seq_sat} : seq_o[i % 3];
      act[i].ffv   = ffv_o[i];
      act[i].ffvec = ffvec_o[i];
      act[i].ffsum = ffsum_o[i];
    end
  end

  // Monitor: drains every expectation queued since the last falling edge.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      sb_t  e;
      obs_t g;
      e = sb_q.pop_front();
      g = act[e.which];
      checks++;
      if (g !== e.exp) begin
        failures++;
        $display("FAIL %s [dut%0d]: got busy=%b done=%b pass=%b vec=%0d err=%0d seq=%0d ffv=%b ffvec=%h ffsum=%h; want busy=%b done=%b pass=%b vec=%0d err=%0d seq=%0d ffv=%b ffvec=%h ffsum=%h",
                 e.name, e.which, g.busy, g.done, g.pass, g.vc, g.err, g.seq, g.ffv, g.ffvec, g.ffsum,
                 e.exp.busy, e.exp.done, e.exp.pass, e.exp.vc, e.exp.err, e.exp.seq, e.exp.ffv,
                 e.exp.ffvec, e.exp.ffsum);
      end
    end
  end

  function automatic void expect_obs(input int which, input string name,
                                     input logic bsy, input logic dn, input logic ps,
                                     input int vc, input int err, input int seq,
                                     input logic ffv, input logic [15:0] ffvec,
                                     input logic [4:0] ffsum);
    sb_t e;
    e.which     = which;
    e.name      = name;
    e.exp.busy  = bsy;
    e.exp.done  = dn;
    e.exp.pass  = ps;
    e.exp.vc    = 17'(vc);
    e.exp.err   = 16'(err);
    e.exp.seq   = 16'(seq);
    e.exp.ffv   = ffv;
    e.exp.ffvec = ffvec;
    e.exp.ffsum = ffsum;
    sb_q.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input int which, input string name);
    checks++;
    if (act[which] !== '0) begin
      failures++;
      $display("FAIL %s [dut%0d]: outputs not all zero (busy=%b done=%b pass=%b vec=%0d err=%0d seq=%0d ffv=%b)",
               name, which, act[which].busy, act[which].done, act[which].pass, act[which].vc,
               act[which].err, act[which].seq, act[which].ffv);
    end
  endtask

  task automatic wait_done(input int which, input int max_cycles, input string name);
    int n;
    n = 0;
    while (done_o[which] !== 1'b1 && n < max_cycles) begin
      tick();
      n++;
    end
    checks++;
    if (done_o[which] !== 1'b1) begin
      failures++;
      $display("FAIL %s [dut%0d]: done not seen within %0d cycles", name, which, max_cycles);
    end
  endtask

  // Drive one valid vector; sum_x/ov_x flip bits of the correct result.
  task automatic send(input logic [15:0] idx, input logic [3:0] sum_x, input logic ov_x);
    int s;
    a = idx[3:0];
    b = idx[7:4];
    c = idx[11:8];
    d = idx[15:12];
    s = int'(a) + int'(b) + int'(c) + int'(d);
    dut_sum   = 4'(s % 16) ^ sum_x;
    dut_ov    = (s > 15) ^ ov_x;
    vec_valid = 1'b1;
    tick();
  endtask

  task automatic pulse_start(input int which);
    start_s[which] = 1'b1;
    tick();
    start_s[which] = 1'b0;
  endtask

  initial begin
    int nvalid;
    for (int i = 0; i < 4; i++) start_s[i] = 1'b0;
    #2;
    for (int i = 0; i < 4; i++) check_idle(i, "reset_direct");
    for (int i = 0; i < 4; i++) expect_obs(i, "reset_state", 0, 0, 0, 0, 0, 0, 0, 16'h0, 5'h0);
    tick();
    rst = 1'b1;
    tick();

    // Mid-run asynchronous reset after 100 vectors.
    pulse_start(FULL);
    expect_obs(FULL, "start_busy", 1, 0, 0, 0, 0, 0, 0, 16'h0, 5'h0);
    for (int i = 0; i < 100; i++) send(i[15:0], 4'h0, 1'b0);
    vec_valid = 1'b0;
    expect_obs(FULL, "run_100", 1, 0, 0, 100, 0, 0, 0, 16'h0, 5'h0);
    tick();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) check_idle(i, "mid_run_reset_direct");
    for (int i = 0; i < 4; i++) expect_obs(i, "mid_run_reset", 0, 0, 0, 0, 0, 0, 0, 16'h0, 5'h0);
    tick();
    rst = 1'b1;
    tick();
    pulse_start(FULL);
    expect_obs(FULL, "restart_after_reset", 1, 0, 0, 0, 0, 0, 0, 16'h0, 5'h0);

    // Full ordered sweep, back-to-back.
    for (int i = 0; i < 65536; i++) begin
      send(i[15:0], 4'h0, 1'b0);
      if (i == 65534) expect_obs(FULL, "sweep_penultimate", 1, 0, 0, 65535, 0, 0, 0, 16'h0, 5'h0);
    end
    vec_valid = 1'b0;
    expect_obs(FULL, "sweep_done", 0, 1, 1, 65536, 0, 0, 0, 16'h0, 5'h0);
    tick();
    wait_done(FULL, 4, "sweep_wait_done");

    // Skipped index 5 on the 16-vector checker, with a start pulse mid-run.
    pulse_start(SMALL);
    for (int i = 0; i <= 16; i++) begin
      if (i == 5) continue;
      if (i == 6) start_s[SMALL] = 1'b1;
      send(i[15:0], 4'h0, 1'b0);
      start_s[SMALL] = 1'b0;
      if (i == 15) expect_obs(SMALL, "skip_15th", 1, 0, 0, 15, 0, 1, 0, 16'h0, 5'h0);
    end
    vec_valid = 1'b0;
    expect_obs(SMALL, "skip_done", 0, 1, 0, 16, 0, 1, 0, 16'h0, 5'h0);
    tick();
    wait_done(SMALL, 4, "skip_wait_done");
    // Start from DONE with a vector in the same cycle: vector is dropped.
    start_s[SMALL] = 1'b1;
    send(16'h0007, 4'h5, 1'b1);
    start_s[SMALL] = 1'b0;
    vec_valid = 1'b0;
    expect_obs(SMALL, "restart_from_done", 1, 0, 0, 0, 0, 0, 0, 16'h0, 5'h0);
    tick();
    for (int i = 0; i < 16; i++) send(i[15:0], 4'h0, 1'b0);
    vec_valid = 1'b0;
    expect_obs(SMALL, "small_clean_pass", 0, 1, 1, 16, 0, 0, 0, 16'h0, 5'h0);
    tick();

    // Fault injection with random gaps on the 64-vector checker.
    pulse_start(FLT);
    nvalid = 0;
    for (int i = 0; i < 64; i++) begin
      while ($urandom_range(0, 2) == 0) begin
        vec_valid = 1'b0;
        {d, c, b, a} = 16'($urandom);
        dut_sum = 4'($urandom);
        dut_ov  = 1'($urandom);
        tick();
      end
      if (i == 16'h1F) send(i[15:0], 4'h0, 1'b1);
      else if (i == 16'h25) send(i[15:0], 4'h3, 1'b0);
      else send(i[15:0], 4'h0, 1'b0);
      nvalid++;
      if (i == 16'h1F) expect_obs(FLT, "first_fault", 1, 0, 0, nvalid, 1, 0, 1, 16'h001F, 5'h00);
      if (i == 39) expect_obs(FLT, "gaps_count_40", 1, 0, 0, 40, 2, 0, 1, 16'h001F, 5'h00);
    end
    vec_valid = 1'b0;
    expect_obs(FLT, "fault_done", 0, 1, 0, 64, 2, 0, 1, 16'h001F, 5'h00);
    // Vectors seen in IDLE/DONE earlier must not have disturbed the others.
    expect_obs(FULL, "done_holds", 0, 1, 1, 65536, 0, 0, 0, 16'h0, 5'h0);
    expect_obs(SAT, "idle_ignores", 0, 0, 0, 0, 0, 0, 0, 16'h0, 5'h0);
    tick();

    // Saturation with ERR_W=4, every result wrong; start+vector from IDLE.
    start_s[SAT] = 1'b1;
    send(16'h0003, 4'h1, 1'b0);
    start_s[SAT] = 1'b0;
    vec_valid = 1'b0;
    expect_obs(SAT, "start_drops_vec", 1, 0, 0, 0, 0, 0, 0, 16'h0, 5'h0);
    tick();
    for (int i = 0; i < 20; i++) begin
      send(i[15:0], 4'h1, 1'b0);
      if (i == 14) expect_obs(SAT, "sat_reach_15", 1, 0, 0, 15, 15, 0, 1, 16'h0000, 5'h01);
      if (i == 15) expect_obs(SAT, "sat_hold_15", 1, 0, 0, 16, 15, 0, 1, 16'h0000, 5'h01);
    end
    vec_valid = 1'b0;
    expect_obs(SAT, "sat_done", 0, 1, 0, 20, 15, 0, 1, 16'h0000, 5'h01);
    tick();
    tick();
    wait_done(SAT, 4, "sat_wait_done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
